// File: rtl/text_display_sequencer.sv
// Steps the text display timer through NUM_MSGS messages and blanks the
// screen for GAP_CYCLES between them. All outputs are registered.
module text_display_sequencer #(
    parameter int NUM_MSGS   = 4,
    parameter int IDX_W      = 2,
    parameter int GAP_CYCLES = 2,
    parameter int LOOP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             timer_done,
    output logic             timer_enable,
    output logic             display_on,
    output logic [IDX_W-1:0] msg_index,
    output logic             busy,
    output logic             seq_done,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSGS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_cnt_nx;
    logic [IDX_W-1:0] idx_nx;

    assign state_dbg = state;

    always_comb begin
        state_nx   = state;
        gap_cnt_nx = gap_cnt;
        idx_nx     = msg_index;
        case (state)
            IDLE: begin
                idx_nx = '0;
                if (start) state_nx = SHOW;
            end
            SHOW: begin
                if (timer_done) begin
                    state_nx   = GAP;
                    gap_cnt_nx = GAP_LOAD;
                end
            end
            GAP: begin
                // The counter reaching zero marks the last blanking cycle.
                if (gap_cnt == '0) begin
                    if (msg_index != LAST_IDX) begin
                        idx_nx   = msg_index + 1'b1;
                        state_nx = SHOW;
                    end else if (LOOP != 0) begin
                        idx_nx   = '0;
                        state_nx = SHOW;
                    end else begin
                        state_nx = FINISH;
                    end
                end else begin
                    gap_cnt_nx = gap_cnt - 1'b1;
                end
            end
            FINISH: begin
                idx_nx   = '0;
                state_nx = IDLE;
            end
            default: begin
                idx_nx   = '0;
                state_nx = IDLE;
            end
        endcase
        if (stop) begin
            state_nx   = IDLE;
            gap_cnt_nx = '0;
            idx_nx     = '0;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            msg_index    <= '0;
            timer_enable <= 1'b0;
            display_on   <= 1'b0;
            busy         <= 1'b0;
            seq_done     <= 1'b0;
        end else begin
            state        <= state_nx;
            gap_cnt      <= gap_cnt_nx;
            msg_index    <= idx_nx;
            timer_enable <= (state_nx == SHOW);
            display_on   <= (state_nx == SHOW);
            busy         <= (state_nx != IDLE);
            seq_done     <= (state_nx == FINISH);
        end
    end

endmodule

// File: tb/tb_text_display_sequencer.sv
// Bench for text_display_sequencer: three parameterisations driven from
// per-cycle stimulus/expectation queues built from the message schedule.
module tb_text_display_sequencer;

    logic       clk;
    logic       reset;
    logic [2:0] start_v;
    logic [2:0] stop_v;
    logic [2:0] td_v;
    logic [2:0] te_v;
    logic [2:0] don_v;
    logic [2:0] busy_v;
    logic [2:0] sd_v;
    logic [1:0] idx_v [3];
    logic [1:0] st_v  [3];

    int checks = 0;
    int errors = 0;

    // stimulus {start, stop, timer_done}; expectation {te, disp, busy, seq_done, idx}
    logic [2:0] stim_q[$];
    logic [5:0] exp_q[$];

    text_display_sequencer #(.NUM_MSGS(4), .IDX_W(2), .GAP_CYCLES(2), .LOOP(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .stop(stop_v[0]), .timer_done(td_v[0]),
        .timer_enable(te_v[0]), .display_on(don_v[0]), .msg_index(idx_v[0]),
        .busy(busy_v[0]), .seq_done(sd_v[0]), .state_dbg(st_v[0]));

    text_display_sequencer #(.NUM_MSGS(3), .IDX_W(2), .GAP_CYCLES(2), .LOOP(1)) dut_loop (
        .clk(clk), .reset(reset), .start(start_v[1]), .stop(stop_v[1]), .timer_done(td_v[1]),
        .timer_enable(te_v[1]), .display_on(don_v[1]), .msg_index(idx_v[1]),
        .busy(busy_v[1]), .seq_done(sd_v[1]), .state_dbg(st_v[1]));

    text_display_sequencer #(.NUM_MSGS(1), .IDX_W(2), .GAP_CYCLES(1), .LOOP(0)) dut_one (
        .clk(clk), .reset(reset), .start(start_v[2]), .stop(stop_v[2]), .timer_done(td_v[2]),
        .timer_enable(te_v[2]), .display_on(don_v[2]), .msg_index(idx_v[2]),
        .busy(busy_v[2]), .seq_done(sd_v[2]), .state_dbg(st_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int nm(input int d);
        return (d == 0) ? 4 : (d == 1) ? 3 : 1;
    endfunction
    function automatic int gap_len(input int d);
        return (d == 2) ? 1 : 2;
    endfunction
    function automatic bit loops(input int d);
        return (d == 1);
    endfunction

    function automatic logic [5:0] e_show(input int i);
        return {4'b1110, 2'(i)};
    endfunction
    function automatic logic [5:0] e_gap(input int i);
        return {4'b0010, 2'(i)};
    endfunction
    function automatic logic [5:0] e_fin(input int i);
        return {4'b0011, 2'(i)};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] observed(input int d);
        return {te_v[d], don_v[d], busy_v[d], sd_v[d], idx_v[d]};
    endfunction

    // Schedule of one sequence: each message is visible for its duration (the
    // cycle timer_done is sampled counts), blank for gap_len cycles, then the
    // next message; a non-looping run ends with one seq_done cycle.
    task automatic build_run(input int d, input int n_run, input int stop_at, input int fixed_dur);
        int dur;
        int idx;
        stim_q.push_back({1'b0, 1'b0, 1'b1}); exp_q.push_back(6'd0);
        stim_q.push_back({1'b1, 1'b0, 1'b0}); exp_q.push_back(e_show(0));
        for (int p = 0; p < n_run; p++) begin
            idx = p % nm(d);
            dur = (fixed_dur != 0) ? fixed_dur : int'($urandom_range(1, 8));
            for (int k = 1; k < dur; k++) begin
                stim_q.push_back({rb(), 1'b0, 1'b0}); exp_q.push_back(e_show(idx));
            end
            if (p == stop_at) begin
                stim_q.push_back({rb(), 1'b1, 1'b1}); exp_q.push_back(6'd0);
                stim_q.push_back({1'b0, 1'b0, 1'b0}); exp_q.push_back(6'd0);
                return;
            end
            stim_q.push_back({rb(), 1'b0, 1'b1}); exp_q.push_back(e_gap(idx));
            for (int k = 1; k < gap_len(d); k++) begin
                stim_q.push_back({rb(), 1'b0, rb()}); exp_q.push_back(e_gap(idx));
            end
            if (p == n_run - 1 && !loops(d)) begin
                stim_q.push_back({rb(), 1'b0, rb()}); exp_q.push_back(e_fin(idx));
                stim_q.push_back({rb(), 1'b0, rb()}); exp_q.push_back(6'd0);
                stim_q.push_back({1'b0, 1'b0, rb()}); exp_q.push_back(6'd0);
                return;
            end
            stim_q.push_back({rb(), 1'b0, rb()}); exp_q.push_back(e_show((p + 1) % nm(d)));
        end
    endtask

    task automatic run_queue(input int d, input string name);
        logic [2:0] s;
        logic [5:0] e;
        int cyc = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            start_v[d] = s[2];
            stop_v[d]  = s[1];
            td_v[d]    = s[0];
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (observed(d) !== e) begin
                errors++;
                $display("FAIL %s dut%0d cycle %0d: got te/disp/busy/done/idx=%b required %b",
                         name, d, cyc, observed(d), e);
            end
            cyc++;
        end
        start_v[d] = 1'b0;
        stop_v[d]  = 1'b0;
        td_v[d]    = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        start_v = '0;
        stop_v  = '0;
        td_v    = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (observed(d) !== 6'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got %b required %b", d, observed(d), 6'd0);
            end
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sequence();
        build_run(0, 4, -1, 10);
        run_queue(0, "seq_fixed10");
        for (int r = 0; r < 4; r++) begin
            build_run(0, 4, -1, 0);
            run_queue(0, "seq_random");
        end
    endtask

    task automatic test_loop();
        for (int r = 0; r < 3; r++) begin
            build_run(1, 9, 3 + int'($urandom_range(0, 4)), 0);
            run_queue(1, "loop_wrap");
        end
    endtask

    task automatic test_stop();
        build_run(0, 4, 1, 0);
        run_queue(0, "stop_with_done");
        build_run(0, 4, -1, 0);
        run_queue(0, "restart_after_stop");
        // stop wins over start while idle
        stim_q.push_back({1'b1, 1'b1, 1'b0}); exp_q.push_back(6'd0);
        run_queue(0, "stop_blocks_start");
    endtask

    task automatic test_async_reset();
        stim_q.push_back({1'b1, 1'b0, 1'b0}); exp_q.push_back(e_show(0));
        stim_q.push_back({1'b0, 1'b0, 1'b0}); exp_q.push_back(e_show(0));
        stim_q.push_back({1'b0, 1'b0, 1'b1}); exp_q.push_back(e_gap(0));
        run_queue(0, "pre_reset");
        #2 reset = 1'b0;
        #1;
        checks++;
        if (observed(0) !== 6'd0) begin
            errors++;
            $display("FAIL async_reset_mid_gap: got %b required %b", observed(0), 6'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            stim_q.push_back({1'b0, 1'b0, rb()}); exp_q.push_back(6'd0);
        end
        run_queue(0, "idle_after_reset");
        build_run(0, 4, -1, 0);
        run_queue(0, "start_after_reset");
    endtask

    task automatic test_single();
        build_run(2, 1, -1, 3);
        run_queue(2, "single_msg");
        build_run(2, 1, -1, 0);
        run_queue(2, "single_msg_random");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            build_run(0, 4, -1, 1);
            run_queue(0, "back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_loop();
        test_stop();
        test_async_reset();
        test_single();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_display_sequencer.md
# text_display_sequencer

Control stage directly upstream of the text display timer. Steps through a fixed list of `NUM_MSGS` on-screen text messages, enabling the timer while each message is shown and advancing on the timer's end-of-time pulse. Inserts a blanking gap between messages so the timer returns to zero. Drives the message index consumed by the text renderer.

## Interface
- `NUM_MSGS`, 4: number of messages in the sequence (≥1).
- `IDX_W`, 2: width of `msg_index`; must satisfy 2^IDX_W ≥ NUM_MSGS.
- `GAP_CYCLES`, 2: blanking cycles between messages (≥1).
- `LOOP`, 0: 1 = wrap to message 0 after the last message; 0 = finish and stop.

- `clk` in 1: the block's single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low. `reset`=0 forces the reset state immediately.
- `start` in 1: level sampled each cycle; starts a sequence from IDLE.
- `stop` in 1: abort; returns to IDLE from any state.
- `timer_done` in 1: end-of-time pulse from the display timer.
- `timer_enable` out 1: enable to the display timer.
- `display_on` out 1: text visible; renderer shows message `msg_index`.
- `msg_index` out IDX_W: current message number.
- `busy` out 1: high in every state except IDLE.
- `seq_done` out 1: one-cycle pulse when a non-looping sequence completes.

## Operation
- States: IDLE, SHOW, GAP, FINISH. All outputs are registered.
- Reset values: state IDLE; `timer_enable`=0, `display_on`=0, `msg_index`=0, `busy`=0, `seq_done`=0, gap counter=0.
- IDLE: all outputs 0, `msg_index`=0.
  - `start`=1 and `stop`=0 → SHOW with `msg_index`=0.
- SHOW: `timer_enable`=1, `display_on`=1, `busy`=1.
  - `timer_done`=1 → GAP and load the gap counter with GAP_CYCLES-1.
- GAP: `timer_enable`=0, `display_on`=0, `busy`=1. The gap counter decrements each cycle.
  - Counter at 0 and `msg_index`<NUM_MSGS-1 → `msg_index`+1, SHOW.
  - Counter at 0 and `msg_index`=NUM_MSGS-1 and LOOP=1 → `msg_index`=0, SHOW.
  - Counter at 0 and `msg_index`=NUM_MSGS-1 and LOOP=0 → FINISH.
- FINISH: lasts exactly one cycle.
  - Outputs: `seq_done`=1, `busy`=1, `timer_enable`=0, `display_on`=0.
  - Next state IDLE with `msg_index`=0.
- Priority and ignored inputs:
  - `stop`=1 overrides everything. The next state is IDLE with all outputs at reset values, and `seq_done` is not pulsed.
  - `start` is ignored outside IDLE.
  - `timer_done` is ignored outside SHOW.
- NUM_MSGS=1: GAP always takes the last-message branch.
- `msg_index` never exceeds NUM_MSGS-1. It wraps only via the LOOP branch.

## Timing
- `start` sampled high in IDLE at edge N → from edge N+1: `timer_enable`=1, `display_on`=1, `msg_index`=0.
- `timer_done` sampled high in SHOW at edge M:
  - From edge M+1: `timer_enable`=0 and `display_on`=0 for exactly GAP_CYCLES cycles.
  - The next SHOW begins at edge M+1+GAP_CYCLES.
- The minimum GAP of 1 cycle guarantees that `timer_enable` is low for at least one clock between messages, which clears the timer's count.
- On the last message with LOOP=0, `seq_done` is high during the cycle after GAP. `busy` falls one cycle later.
- `stop` at edge K → outputs at reset values from edge K+1.
- `reset` asserted mid-sequence → outputs go to reset values immediately (asynchronously). After release, the block waits in IDLE for a fresh `start`.
- `timer_done` and `stop` high in the same SHOW cycle → IDLE; no GAP is entered.

## Test plan
- Reset, then `start` pulse; NUM_MSGS=4, GAP_CYCLES=2, LOOP=0; each `timer_done` issued 10 cycles after SHOW entry:
  - `msg_index` steps 0,1,2,3.
  - `timer_enable` is low for exactly 2 cycles between messages.
  - `seq_done` is high for 1 cycle after the last GAP.
  - `busy` falls the cycle after `seq_done`.
- LOOP=1, NUM_MSGS=3: after message 2's `timer_done` and the gap, `msg_index` returns to 0 and `seq_done` stays 0 throughout.
- `stop` asserted during SHOW of message 1, same cycle as `timer_done`:
  - Next cycle: IDLE, all outputs 0, `msg_index`=0, no `seq_done`.
  - A subsequent `start` restarts from message 0.
- `start` held high during SHOW/GAP and `timer_done` pulsed during GAP and IDLE: no restart, no index change, no state change.
- `reset` driven to 0 asynchronously mid-GAP: outputs 0 before the next clock edge; the block remains IDLE after release until `start`.
- NUM_MSGS=1, GAP_CYCLES=1, LOOP=0: `start` → SHOW(0) → `timer_done` → 1 GAP cycle → FINISH (`seq_done`=1) → IDLE.
